bus_rr_arbiter: RTL and testbench



---
 rtl/bus_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner arbitration for a shared transfer bus.
// Grants one producer at a time and holds the grant until the consumer accepts.
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-high reset
//   req       per-device request (bit i = device i)
//   accepted  consumer accept strobe, single-cycle pulse
//   gnt       one-hot registered grant
//   acc_out   one-hot accept routed to the current owner (combinational)
//   gnt_id    index of the current or last owner
//   busy      bus currently owned
//   timeout   one-cycle pulse when the watchdog revokes a grant
//
// Optional build macro ARB_TIMEOUT_EN adds a grant watchdog of TIMEOUT cycles;
// without it no counter is built and timeout stays 0.

module bus_rr_arbiter #(
    parameter int N       = 2,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           accepted,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   acc_out,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    // Elaboration-time parameter sanity checks.
    if (N < 2 || N > 8) begin : g_bad_n
        $error("bus_rr_arbiter: N must be 2..8");
    end
    if ((1 << IDW) < N) begin : g_bad_idw
        $error("bus_rr_arbiter: IDW too narrow for N");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_to
        $error("bus_rr_arbiter: TIMEOUT must be 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [N-1:0]   win_oh;
    logic           expire;

    // Winner search from ptr upward, wrapping. The wrap-around pass runs
    // first so that any hit at or above ptr overrides it; within each pass
    // the descending loop leaves the lowest index as the last assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i < int'(ptr))) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N; i++) begin
            win_oh[i] = (win_idx == IDW'(i));
        end
    end

    // Priority moves to the device just after the releasing owner.
    assign ptr_next = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

    // gnt is only non-zero in OWNED; the state term makes that explicit.
    assign acc_out = (state == OWNED) ? (gnt & {N{accepted}}) : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = 16;

    logic [CW-1:0] wd_cnt;

    // An accept on the expiry cycle wins over the watchdog.
    assign expire = (state == OWNED) && !accepted
                    && (wd_cnt == CW'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        state  <= OWNED;
                        gnt    <= win_oh;
                        gnt_id <= win_idx;
                        busy   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                OWNED: begin
                    if (accepted || expire) begin
                        state   <= RELEASE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= ptr_next;
                        timeout <= expire;
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                // Dead cycle so producers observe gnt low before a re-grant.
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed self-checking bench for bus_rr_arbiter.
// N=2, TIMEOUT=8; watchdog cases run when ARB_TIMEOUT_EN is defined.

module tb_bus_rr_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] req;
    logic       accepted;
    logic [1:0] gnt;
    logic [1:0] acc_out;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;

    bus_rr_arbiter #(
        .N       (2),
        .IDW     (3),
        .TIMEOUT (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .accepted (accepted),
        .gnt      (gnt),
        .acc_out  (acc_out),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] oh;
        int         dev;

        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        req      = 2'b00;
        accepted = 1'b0;

        tick();
        tick();
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_id", gnt_id, 3'd0);
        check("rst_acc", acc_out, 2'b00);
        check("rst_to", timeout, 1'b0);
        reset = 1'b0;

        // Single requester, one-cycle grant latency, accept at cycle 4.
        req = 2'b01;
        tick();
        check("t1_gnt", gnt, 2'b01);
        check("t1_busy", busy, 1'b1);
        check("t1_id", gnt_id, 3'd0);
        req = 2'b00;
        tick();
        tick();
        check("t1_hold", gnt, 2'b01);
        tick();
        accepted = 1'b1;
        #1;
        check("t1_acc", acc_out, 2'b01);
        tick();
        accepted = 1'b0;
        check("t1_rel_gnt", gnt, 2'b00);
        check("t1_rel_busy", busy, 1'b0);
        check("t1_rel_id", gnt_id, 3'd0);
        tick();
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_gnt", gnt, 2'b00);

        // Contention: ptr is now 1, so device 1 wins first, then alternate.
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            dev = (g % 2 == 0) ? 1 : 0;
            oh  = (dev == 1) ? 2'b10 : 2'b01;
            tick();
            check("rr_gnt", gnt, oh);
            check("rr_id", gnt_id, dev);
            tick();
            tick();
            accepted = 1'b1;
            #1;
            check("rr_acc", acc_out, oh);
            tick();
            accepted = 1'b0;
            check("rr_rel", gnt, 2'b00);
            tick();
        end
        req = 2'b00;

        // Spurious accepts in IDLE and RELEASE; routing to owner 1.
        accepted = 1'b1;
        #1;
        check("sp_idle_acc", acc_out, 2'b00);
        tick();
        check("sp_idle_busy", busy, 1'b0);
        check("sp_idle_gnt", gnt, 2'b00);
        accepted = 1'b0;
        req = 2'b10;
        tick();
        check("sp_gnt1", gnt, 2'b10);
        req = 2'b00;
        accepted = 1'b1;
        #1;
        check("sp_route", acc_out, 2'b10);
        tick();
        check("sp_rel_acc", acc_out, 2'b00);
        check("sp_rel_gnt", gnt, 2'b00);
        tick();
        check("sp_idle2_acc", acc_out, 2'b00);
        check("sp_idle2_busy", busy, 1'b0);
        accepted = 1'b0;

        // Asynchronous reset during a grant.
        req = 2'b10;
        tick();
        check("ar_gnt", gnt, 2'b10);
        req = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        check("ar_gnt0", gnt, 2'b00);
        check("ar_busy0", busy, 1'b0);
        check("ar_id0", gnt_id, 3'd0);
        #1;
        reset = 1'b0;
        tick();
        req = 2'b11;
        tick();
        check("ar_ptr0", gnt, 2'b01);
        req = 2'b00;
        accepted = 1'b1;
        tick();
        accepted = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req = 2'b01;
        tick();
        check("wd_gnt0", gnt, 2'b01);
        req = 2'b10;
        for (int k = 1; k < 8; k++) begin
            tick();
            check("wd_hold", gnt, 2'b01);
            check("wd_no_to", timeout, 1'b0);
        end
        tick();
        check("wd_rev_gnt", gnt, 2'b00);
        check("wd_rev_to", timeout, 1'b1);
        check("wd_rev_busy", busy, 1'b0);
        tick();
        check("wd_to_pulse", timeout, 1'b0);
        check("wd_idle_gnt", gnt, 2'b00);
        tick();
        check("wd_next_gnt", gnt, 2'b10);
        check("wd_next_id", gnt_id, 3'd1);
        req = 2'b00;
        repeat (7) tick();
        accepted = 1'b1;
        #1;
        check("wd_exp_acc", acc_out, 2'b10);
        tick();
        accepted = 1'b0;
        check("wd_exp_gnt", gnt, 2'b00);
        check("wd_exp_to", timeout, 1'b0);
        tick();
        check("wd_exp_to2", timeout, 1'b0);
`else
        req = 2'b01;
        tick();
        check("nowd_gnt", gnt, 2'b01);
        req = 2'b00;
        repeat (70) tick();
        check("nowd_hold", gnt, 2'b01);
        check("nowd_to", timeout, 1'b0);
        accepted = 1'b1;
        tick();
        accepted = 1'b0;
        check("nowd_rel", gnt, 2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
